// File: rtl/e32_config_controller.sv
// E32 config-mode command parser: collects C0..C4 frames, owns the five config registers, queues replies.
// Latency: a command executes END_PROCESS_COMMAND cycles after its last byte; reply bytes follow at most every 2nd cycle.
// Backpressure: tx_ready=0 stalls the reply indefinitely; rx bytes outside IDLE/COLLECT are dropped, never buffered.
module e32_config_controller #(
  parameter int          TIMEOUT_CYCLES      = 960,
  parameter int          END_PROCESS_COMMAND = 6250,
  parameter int          END_PROCESS_RESET   = 12500,
  parameter logic [7:0]  VERSION_BYTE        = 8'h0D,
  parameter logic [7:0]  FEATURE_BYTE        = 8'h14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_use,
  output logic       aux,
  output logic       reset_req,
  output logic [7:0] addh,
  output logic [7:0] addl,
  output logic [7:0] sped,
  output logic [7:0] chan,
  output logic [7:0] option,
  output logic       cfg_update,
  output logic       cfg_saved
);

  // One timer serves the byte gap, the processing delay and the reset hold, so it is sized for the largest.
  localparam int MAX_A = (TIMEOUT_CYCLES > END_PROCESS_COMMAND) ? TIMEOUT_CYCLES : END_PROCESS_COMMAND;
  localparam int MAX_P = (MAX_A > END_PROCESS_RESET) ? MAX_A : END_PROCESS_RESET;
  localparam int TW    = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] EXEC_LAST = TW'(END_PROCESS_COMMAND - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(END_PROCESS_RESET - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_PROCESS, S_RESPOND, S_RESET_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [2:0]    cnt_q, cnt_d, cnt_inc;
  logic [2:0]    len_q, len_d;
  // Frame buffer; after execution it is rewritten in place with the reply bytes.
  logic [7:0]    frm_q [6];
  logic [7:0]    frm_d [6];
  logic [7:0]    addh_q, addh_d, addl_q, addl_d, sped_q, sped_d;
  logic [7:0]    chan_q, chan_d, option_q, option_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_use_q, tx_use_d;
  logic          aux_q, aux_d;
  logic          reset_req_q, reset_req_d;
  logic          cfg_update_q, cfg_update_d;
  logic          cfg_saved_q, cfg_saved_d;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    frm_d        = frm_q;
    addh_d       = addh_q;
    addl_d       = addl_q;
    sped_d       = sped_q;
    chan_d       = chan_q;
    option_d     = option_q;
    tx_data_d    = tx_data_q;
    tx_use_d     = 1'b0;
    aux_d        = aux_q;
    reset_req_d  = 1'b0;
    cfg_update_d = 1'b0;
    cfg_saved_d  = cfg_saved_q;
    cnt_inc      = cnt_q + 3'd1;
    timer_inc    = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_ONE;

    case (state_q)
      S_IDLE: begin
        aux_d = 1'b1;
        if (rx_flag && mode == 2'b11) begin
          case (rx_data)
            8'hC0, 8'hC2: begin
              frm_d[0] = rx_data;
              len_d    = 3'd6;
              cnt_d    = 3'd1;
              timer_d  = '0;
              state_d  = S_COLLECT;
            end
            8'hC1, 8'hC3, 8'hC4: begin
              frm_d[0] = rx_data;
              len_d    = 3'd3;
              cnt_d    = 3'd1;
              timer_d  = '0;
              state_d  = S_COLLECT;
            end
            default: ;
          endcase
        end
      end

      S_COLLECT: begin
        if (mode != 2'b11) begin
          state_d = S_IDLE;
        end else if (rx_flag) begin
          // A byte landing on the expiry cycle still counts, so rx_flag is tested before the timer.
          frm_d[cnt_q] = rx_data;
          timer_d      = '0;
          if (len_q == 3'd3 && rx_data != frm_q[0]) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = S_PROCESS;
              aux_d   = 1'b0;
              // The cycle of the final byte is the first counted processing cycle.
              timer_d = TMR_ONE;
            end
          end
        end else if (timer_q >= GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_PROCESS: begin
        aux_d = 1'b0;
        if (timer_q >= EXEC_LAST) begin
          timer_d = '0;
          cnt_d   = 3'd0;
          state_d = S_RESPOND;
          case (frm_q[0])
            8'hC0, 8'hC2: begin
              addh_d       = frm_q[1];
              addl_d       = frm_q[2];
              sped_d       = frm_q[3];
              chan_d       = frm_q[4];
              option_d     = frm_q[5];
              cfg_update_d = 1'b1;
              cfg_saved_d  = (frm_q[0] == 8'hC0);
              len_d        = 3'd6;
            end
            8'hC1: begin
              frm_d[0] = 8'hC0;
              frm_d[1] = addh_q;
              frm_d[2] = addl_q;
              frm_d[3] = sped_q;
              frm_d[4] = chan_q;
              frm_d[5] = option_q;
              len_d    = 3'd6;
            end
            8'hC3: begin
              frm_d[0] = 8'hC3;
              frm_d[1] = 8'h32;
              frm_d[2] = VERSION_BYTE;
              frm_d[3] = FEATURE_BYTE;
              len_d    = 3'd4;
            end
            8'hC4: begin
              reset_req_d = 1'b1;
              state_d     = S_RESET_HOLD;
            end
            default: ;
          endcase
        end else begin
          timer_d = timer_inc;
        end
      end

      S_RESPOND: begin
        aux_d = 1'b0;
        // tx_use_q blocks back-to-back strobes so the transmitter sees at least one idle cycle.
        if (tx_ready && !tx_use_q) begin
          tx_data_d = frm_q[cnt_q];
          tx_use_d  = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_IDLE;
            aux_d   = 1'b1;
          end
        end
      end

      S_RESET_HOLD: begin
        aux_d = 1'b0;
        if (timer_q >= HOLD_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          aux_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset to the power-on configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      for (int i = 0; i < 6; i++) frm_q[i] <= 8'h00;
      addh_q       <= 8'h00;
      addl_q       <= 8'h00;
      sped_q       <= 8'h1A;
      chan_q       <= 8'h17;
      option_q     <= 8'h44;
      tx_data_q    <= 8'h00;
      tx_use_q     <= 1'b0;
      aux_q        <= 1'b1;
      reset_req_q  <= 1'b0;
      cfg_update_q <= 1'b0;
      cfg_saved_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      frm_q        <= frm_d;
      addh_q       <= addh_d;
      addl_q       <= addl_d;
      sped_q       <= sped_d;
      chan_q       <= chan_d;
      option_q     <= option_d;
      tx_data_q    <= tx_data_d;
      tx_use_q     <= tx_use_d;
      aux_q        <= aux_d;
      reset_req_q  <= reset_req_d;
      cfg_update_q <= cfg_update_d;
      cfg_saved_q  <= cfg_saved_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_use     = tx_use_q;
  assign aux        = aux_q;
  assign reset_req  = reset_req_q;
  assign addh       = addh_q;
  assign addl       = addl_q;
  assign sped       = sped_q;
  assign chan       = chan_q;
  assign option     = option_q;
  assign cfg_update = cfg_update_q;
  assign cfg_saved  = cfg_saved_q;

endmodule

// File: tb/tb_e32_config_controller.sv
// Bench for e32_config_controller: expected reply bytes are queued as frames are sent and
// compared against bytes captured on tx_use; each scenario task checks its own results.
module tb_e32_config_controller;
  localparam int TO = 960;
  localparam int NC = 6250;
  localparam int NR = 12500;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_use;
  logic       aux;
  logic       reset_req;
  logic [7:0] addh, addl, sped, chan, option;
  logic       cfg_update;
  logic       cfg_saved;

  e32_config_controller dut (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_flag(rx_flag),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_use(tx_use), .aux(aux),
    .reset_req(reset_req), .addh(addh), .addl(addl), .sped(sped), .chan(chan),
    .option(option), .cfg_update(cfg_update), .cfg_saved(cfg_saved)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         tx_events   = 0;
  int         spacing_bad = 0;
  int         rr_cnt      = 0;
  logic       prev_use    = 1'b0;
  logic       prev_ready  = 1'b0;
  logic [7:0] m_reg [5];

  // Output monitor: captures reply bytes and flags strobes that break the 2-cycle / tx_ready rule.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      prev_use   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (tx_use === 1'b1) begin
        got_q.push_back(tx_data);
        tx_events++;
        if (prev_use || !prev_ready) spacing_bad++;
      end
      if (reset_req === 1'b1) rr_cnt++;
      prev_use   = tx_use;
      prev_ready = tx_ready;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0t required completion", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    for (int i = 0; i < f.size(); i++) send_byte(f[i]);
  endtask

  task automatic send3(input logic [7:0] b);
    for (int i = 0; i < 3; i++) send_byte(b);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b11; rx_flag = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_assert++;
    if ({addh, addl, sped, chan, option} !== 40'h00_00_1A_17_44) begin
      n_fail++;
      $display("FAIL reset_regs: got %h required 00001a1744", {addh, addl, sped, chan, option});
    end
    n_assert++;
    if ({tx_data, tx_use, aux, reset_req, cfg_update, cfg_saved} !== {8'h00, 5'b01000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required %h",
               {tx_data, tx_use, aux, reset_req, cfg_update, cfg_saved}, {8'h00, 5'b01000});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) m_reg[i] = (i == 2) ? 8'h1A : (i == 3) ? 8'h17 : (i == 4) ? 8'h44 : 8'h00;
    tick();
  endtask

  task automatic test_write_persistent();
    logic [7:0] f[$];
    logic [7:0] e, g;
    int         lat;
    logic       aux1;
    bit         ok;
    f = '{8'hC0, 8'hCD, 8'hAB, 8'h3D, 8'h17, 8'hC4};
    got_q.delete(); exp_q.delete();
    foreach (f[i]) exp_q.push_back(f[i]);
    for (int i = 0; i < 5; i++) m_reg[i] = f[i+1];
    aux1 = 1'b1;
    send_frame(f);
    for (lat = 1; lat <= NC + 50; lat++) begin
      @(negedge clk);
      if (lat == 1) aux1 = aux;
      if (cfg_update === 1'b1) break;
    end
    n_assert++;
    if (aux1 !== 1'b0) begin n_fail++; $display("FAIL write_aux_busy: got %b required 0", aux1); end
    n_assert++;
    if (lat != NC) begin n_fail++; $display("FAIL write_exec_latency: got %0d required %0d", lat, NC); end
    n_assert++;
    if ({addh, addl, sped, chan, option} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]}) begin
      n_fail++;
      $display("FAIL write_regs: got %h required %h", {addh, addl, sped, chan, option},
               {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]});
    end
    n_assert++;
    if (cfg_saved !== 1'b1) begin n_fail++; $display("FAIL write_saved: got %b required 1", cfg_saved); end
    @(negedge clk);
    n_assert++;
    if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL write_update_width: got %b required 0", cfg_update); end
    n_assert++;
    if (aux !== 1'b0) begin n_fail++; $display("FAIL write_aux_respond: got %b required 0", aux); end
    wait_bytes(6, 100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL write_echo_timeout: got %0d bytes required 6", got_q.size()); end
    n_assert++;
    if (aux !== 1'b1) begin n_fail++; $display("FAIL write_aux_release: got %b required 1", aux); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL write_echo_byte: got %h required %h", g, e); end
    end
    repeat (5) tick();
    n_assert++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL write_extra_bytes: got %0d required 0", got_q.size()); end
  endtask

  task automatic test_readback();
    logic [7:0] f[$];
    logic [7:0] e, g;
    int         lat;
    bit         ok;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 5; i++) exp_q.push_back(m_reg[i]);
    send3(8'hC1);
    wait_bytes(6, NC + 100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL readback_timeout: got %0d bytes required 6", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL readback_byte: got %h required %h", g, e); end
    end
    repeat (3) tick();
    f = '{8'hC2, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
    got_q.delete(); exp_q.delete();
    foreach (f[i]) exp_q.push_back(f[i]);
    for (int i = 0; i < 5; i++) m_reg[i] = f[i+1];
    send_frame(f);
    for (lat = 1; lat <= NC + 50; lat++) begin
      @(negedge clk);
      if (cfg_update === 1'b1) break;
    end
    n_assert++;
    if (cfg_saved !== 1'b0 || lat != NC) begin
      n_fail++;
      $display("FAIL volatile_write: got saved=%b lat=%0d required saved=0 lat=%0d", cfg_saved, lat, NC);
    end
    wait_bytes(6, 100, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL volatile_echo_byte: got %h required %h", g, e); end
    end
    repeat (3) tick();
  endtask

  task automatic test_version();
    logic [7:0] e, g;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(8'hC3); exp_q.push_back(8'h32); exp_q.push_back(8'h0D); exp_q.push_back(8'h14);
    tx_ready = 1'b0;
    send3(8'hC3);
    repeat (NC + 20) tick();
    n_assert++;
    if (got_q.size() != 0 || aux !== 1'b0) begin
      n_fail++;
      $display("FAIL version_stall: got %0d bytes aux=%b required 0 bytes aux=0", got_q.size(), aux);
    end
    for (int i = 0; i < 300 && got_q.size() < 4; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    n_assert++;
    if (got_q.size() != 4) begin n_fail++; $display("FAIL version_count: got %0d required 4", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL version_byte: got %h required %h", g, e); end
    end
    n_assert++;
    if (spacing_bad != 0) begin n_fail++; $display("FAIL tx_spacing: got %0d violations required 0", spacing_bad); end
    repeat (3) tick();
  endtask

  task automatic test_reset_cmd();
    int lat, hold, tx0, rr0;
    got_q.delete();
    tx0 = tx_events;
    rr0 = rr_cnt;
    send3(8'hC4);
    for (lat = 1; lat <= NC + 50; lat++) begin
      @(negedge clk);
      if (reset_req === 1'b1) break;
    end
    n_assert++;
    if (lat != NC) begin n_fail++; $display("FAIL reset_req_latency: got %0d required %0d", lat, NC); end
    hold = 0;
    while (aux === 1'b0 && hold < NR + 100) begin
      hold++;
      @(negedge clk);
    end
    n_assert++;
    if (hold != NR) begin n_fail++; $display("FAIL reset_hold_cycles: got %0d required %0d", hold, NR); end
    repeat (5) tick();
    n_assert++;
    if (rr_cnt - rr0 != 1) begin n_fail++; $display("FAIL reset_req_pulses: got %0d required 1", rr_cnt - rr0); end
    n_assert++;
    if (tx_events != tx0) begin n_fail++; $display("FAIL reset_tx_activity: got %0d required 0", tx_events - tx0); end
    n_assert++;
    if ({addh, addl, sped, chan, option} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]}) begin
      n_fail++;
      $display("FAIL reset_cmd_regs: got %h required %h", {addh, addl, sped, chan, option},
               {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]});
    end
  endtask

  task automatic test_malformed();
    logic [7:0] f[$];
    logic [7:0] e, g;
    bit         aux_hi;
    bit         ok;
    got_q.delete();
    f = '{8'hC1, 8'hC1, 8'hC2};
    send_frame(f);
    aux_hi = 1'b1;
    repeat (50) begin @(negedge clk); if (aux !== 1'b1) aux_hi = 1'b0; end
    n_assert++;
    if (!aux_hi || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_head_frame: got aux_hi=%b bytes=%0d required 1 and 0", aux_hi, got_q.size());
    end
    send_byte(8'h55);
    aux_hi = 1'b1;
    repeat (50) begin @(negedge clk); if (aux !== 1'b1) aux_hi = 1'b0; end
    n_assert++;
    if (!aux_hi || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL stray_byte: got aux_hi=%b bytes=%0d required 1 and 0", aux_hi, got_q.size());
    end
    f = '{8'hC0, 8'hAA, 8'hBB};
    send_frame(f);
    repeat (TO + 10) tick();
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 5; i++) exp_q.push_back(m_reg[i]);
    send3(8'hC1);
    wait_bytes(6, NC + 100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL timeout_readback_count: got %0d required 6", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_assert++;
      if (g !== e) begin n_fail++; $display("FAIL timeout_readback_byte: got %h required %h", g, e); end
    end
    repeat (3) tick();
  endtask

  task automatic test_mode();
    bit aux_hi;
    got_q.delete();
    mode = 2'b00;
    send3(8'hC1);
    aux_hi = 1'b1;
    repeat (50) begin @(negedge clk); if (aux !== 1'b1) aux_hi = 1'b0; end
    n_assert++;
    if (!aux_hi || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL mode00_ignored: got aux_hi=%b bytes=%0d required 1 and 0", aux_hi, got_q.size());
    end
    tick();
    mode = 2'b11;
    send_byte(8'hC1);
    send_byte(8'hC1);
    mode = 2'b00;
    tick();
    mode = 2'b11;
    send_byte(8'hC1);
    aux_hi = 1'b1;
    repeat (50) begin @(negedge clk); if (aux !== 1'b1) aux_hi = 1'b0; end
    n_assert++;
    if (!aux_hi || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL mode_drop_collect: got aux_hi=%b bytes=%0d required 1 and 0", aux_hi, got_q.size());
    end
    repeat (TO + 10) tick();
  endtask

  task automatic test_rst_respond();
    logic [7:0] f[$];
    int         lat;
    bit         ok;
    got_q.delete();
    tx_ready = 1'b0;
    f = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(f);
    for (lat = 1; lat <= NC + 50; lat++) begin
      @(negedge clk);
      if (cfg_update === 1'b1) break;
    end
    n_assert++;
    if ({addh, addl, sped, chan, option} !== 40'h11_22_33_44_55) begin
      n_fail++;
      $display("FAIL rst_pre_regs: got %h required 1122334455", {addh, addl, sped, chan, option});
    end
    tick();
    tx_ready = 1'b1;
    wait_bytes(2, 50, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL rst_partial_reply: got %0d bytes required 2", got_q.size()); end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_assert++;
    if ({addh, addl, sped, chan, option} !== 40'h00_00_1A_17_44) begin
      n_fail++;
      $display("FAIL rst_mid_regs: got %h required 00001a1744", {addh, addl, sped, chan, option});
    end
    n_assert++;
    if ({tx_data, tx_use, aux, reset_req, cfg_update, cfg_saved} !== {8'h00, 5'b01000}) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h required %h",
               {tx_data, tx_use, aux, reset_req, cfg_update, cfg_saved}, {8'h00, 5'b01000});
    end
    rst = 1'b0;
    got_q.delete();
    repeat (20) tick();
    n_assert++;
    if (got_q.size() != 0 || aux !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_abandon_reply: got bytes=%0d aux=%b required 0 and 1", got_q.size(), aux);
    end
  endtask

  initial begin
    test_reset();
    test_write_persistent();
    test_readback();
    test_version();
    test_reset_cmd();
    test_malformed();
    test_mode();
    test_rst_respond();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/e32_config_controller.md
# e32_config_controller

Configuration-command controller for the RF transceiver's MCU-side UART in sleep/config mode (M1M0 = 11). Parses the byte stream from the MCU UART receiver into E32-style commands (C0/C2 write, C1 read-back, C3 version, C4 reset), owns the five configuration registers, and sequences response bytes into the MCU UART transmitter. It drives AUX busy while a command is being processed and issues the module reset request.

## Interface
- `TIMEOUT_CYCLES`, 960: maximum idle gap between bytes of one frame; reaching it discards the partial frame.
- `END_PROCESS_COMMAND`, 6250: busy cycles between the last byte of a frame and its execution.
- `END_PROCESS_RESET`, 12500: busy cycles held after a reset command.
- `VERSION_BYTE`, 8'h0D: third byte of the C3 response.
- `FEATURE_BYTE`, 8'h14: fourth byte of the C3 response.
- `clk  in  1` — the single clock; all logic is on its rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `mode  in  2` — current M1M0 mode; commands are accepted only when it is 2'b11.
- `rx_data  in  8` — byte from the MCU UART receiver.
- `rx_flag  in  1` — one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_ready  in  1` — the MCU UART transmitter can accept a byte.
- `tx_data  out  8` — response byte to the transmitter.
- `tx_use  out  1` — one-cycle strobe qualifying `tx_data`.
- `aux  out  1` — 1 = ready, 0 = busy.
- `reset_req  out  1` — one-cycle module-reset request.
- `addh`, `addl`, `sped`, `chan`, `option`  out  8 each — configuration registers.
- `cfg_update  out  1` — one-cycle strobe when the registers change.
- `cfg_saved  out  1` — 1 if the last write used head C0 (persistent); 0 if it used head C2.

## Operation
- **Reset values:**
  - `addh` = 00, `addl` = 00, `sped` = 1A, `chan` = 17, `option` = 44.
  - `tx_data` = 00, `tx_use` = 0, `aux` = 1, `reset_req` = 0, `cfg_update` = 0, `cfg_saved` = 0.
  - state = IDLE; byte count and timers = 0.
- **States:** IDLE, COLLECT, PROCESS, RESPOND, RESET_HOLD.
- **IDLE:**
  - On `rx_flag` with `mode`=11: if the byte is C0 or C2, store it, set expected length 6 and go to COLLECT.
  - If the byte is C1, C3 or C4: set expected length 3 and go to COLLECT.
  - Any other byte is dropped and the state stays IDLE.
  - Bytes arriving with `mode`≠11 are ignored.
- **COLLECT:**
  - Each `rx_flag` stores the byte into a 6-entry buffer and clears the gap timer.
  - In a 3-byte frame, a byte different from the head drops the whole frame; go to IDLE without re-parsing that byte.
  - When the byte count reaches the expected length, go to PROCESS.
  - Gap timer reaching `TIMEOUT_CYCLES`, or `mode` leaving 11, sends the state to IDLE and discards the frame.
  - If `rx_flag` and timer expiry occur in the same cycle, the byte is accepted.
- **PROCESS:**
  - `aux`=0; count `END_PROCESS_COMMAND` cycles, then execute the command.
  - C0/C2: load the five registers from buffer bytes 1..5, pulse `cfg_update`, set `cfg_saved` = (head==C0). Response is the 6 frame bytes as received.
  - C1: response is C0, addh, addl, sped, chan, option.
  - C3: response is C3, 32, `VERSION_BYTE`, `FEATURE_BYTE`.
  - C4: pulse `reset_req`, then go to RESET_HOLD. There is no response, and registers are unchanged.
  - All other commands go to RESPOND.
- **RESPOND:**
  - `aux`=0.
  - Emit response bytes in order. A byte is sent on a cycle where `tx_ready`=1 and `tx_use` was 0 in the previous cycle, so strobes are at least 2 cycles apart.
  - After the last byte, go to IDLE.
- **RESET_HOLD:** `aux`=0 for `END_PROCESS_RESET` cycles, then go to IDLE.
- **Ignored input:** `rx_flag` during PROCESS, RESPOND or RESET_HOLD is ignored.
- **Mode change after collection:** a `mode` change in PROCESS, RESPOND or RESET_HOLD does not abort; the command completes.
- **Reset mid-operation:** `rst` at any point restores all reset values, including the registers. A partial response is abandoned.

## Timing
- **Byte latch:** a byte is latched in the cycle its `rx_flag` is high.
- **PROCESS entry:** PROCESS is entered on the next edge.
- **Execution:** registers, `cfg_update`, `cfg_saved` and `reset_req` take effect exactly `END_PROCESS_COMMAND` cycles after the final byte's `rx_flag` cycle.
- **First response byte:** `tx_use` for the first byte occurs no earlier than the cycle after execution, and is gated by `tx_ready`.
- **Data valid:** `tx_data` is valid during every cycle `tx_use`=1.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.
- **AUX release:** `aux` returns to 1 in the cycle IDLE is re-entered.
- **Timers:** counters are sized ⌈log2(max parameter + 1)⌉ and saturate; they never wrap.

## Test plan
- **Write, persistent:** mode 11; send C0 CD AB 3D 17 C4. Expect registers CD/AB/3D/17/C4, `cfg_update` 1 cycle, `cfg_saved`=1, echo C0 CD AB 3D 17 C4, and `aux` low from the last byte until the echo ends.
- **Read-back:** after the write test, send C1 C1 C1. Expect response C0 CD AB 3D 17 C4. Then send C2 00 00 1A 17 44 and expect `cfg_saved`=0.
- **Version:** send C3 C3 C3. Expect C3 32 0D 14, with `tx_use` strobes ≥2 cycles apart and stalled while `tx_ready`=0.
- **Reset command:** send C4 C4 C4. Expect `reset_req` pulsed exactly once, `aux`=0 for `END_PROCESS_RESET` cycles, no TX activity, and registers unchanged.
- **Malformed frames:**
  - C1 C1 C2 → no response, `aux` stays 1.
  - C0 plus 2 bytes, then a gap of `TIMEOUT_CYCLES` → frame discarded; a following C1 C1 C1 returns the old configuration.
  - Byte 55 in IDLE → ignored.
- **Mode and reset:** with `mode`=00, C1 C1 C1 is ignored. With `mode` 11→00 mid-COLLECT, the frame is dropped. `rst` asserted during RESPOND → outputs return to reset values the next cycle and registers are back to defaults.
